// File: rtl/debug_ctrl_pkg.sv
// debug_ctrl_pkg: command, status and state encodings shared by the debug halt controller
package debug_ctrl_pkg;
  typedef enum logic [1:0] {CMD_NOP, CMD_HALT, CMD_RESUME, CMD_CLR_RST} dbg_cmd_e;
  typedef enum logic [1:0] {RSP_OK, RSP_TIMEOUT, RSP_ILLEGAL} dbg_status_e;
  typedef enum logic [1:0] {S_IDLE, S_HALT_REQ, S_HALTED, S_RESUME_WAIT} dbg_state_e;
endpackage

// File: rtl/dbg_timeout_timer.sv
// dbg_timeout_timer: wait counter shared by halt and resume, expired on the last allowed cycle
module dbg_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/debug_halt_ctrl.sv
// debug_halt_ctrl: sequences core halt/resume over the debug pins with per-command status
module debug_halt_ctrl
  import debug_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  output logic             rsp_valid_o,
  output logic [1:0]       rsp_status_o,
  output logic             debug_req_o,
  input  logic             debug_havereset_i,
  input  logic             debug_running_i,
  input  logic             debug_halted_i,
  output logic             halted_o,
  output logic             have_reset_o,
  output logic             halt_event_o,
  output logic [CNT_W-1:0] halt_count_o
);
  dbg_state_e state_q, state_d;
  dbg_status_e rsp_d;
  dbg_cmd_e op;
  logic hs, clr, expired, rsp_v_d, evt_d, halt_entry;
  assign op = dbg_cmd_e'(cmd_op_i);
  assign hs = cmd_valid_i && cmd_ready_o;
  dbg_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en(state_q == S_HALT_REQ || state_q == S_RESUME_WAIT),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    rsp_v_d = 1'b0;
    rsp_d = RSP_OK;
    clr = 1'b0;
    evt_d = 1'b0;
    case (state_q)
      S_IDLE:
        if (hs && op == CMD_HALT) begin
          state_d = S_HALT_REQ;
          clr = 1'b1;
        end else if (hs) begin
          rsp_v_d = 1'b1;
          rsp_d = op == CMD_RESUME ? RSP_ILLEGAL : RSP_OK;
        end else if (debug_halted_i) begin
          state_d = S_HALTED;
          evt_d = 1'b1;
        end
      S_HALTED:
        if (hs && op == CMD_RESUME) begin
          state_d = S_RESUME_WAIT;
          clr = 1'b1;
        end else if (hs) begin
          rsp_v_d = 1'b1;
          rsp_d = op == CMD_HALT ? RSP_ILLEGAL : RSP_OK;
        end else if (debug_running_i) state_d = S_IDLE;
      // halted beats a timeout expiring in the same cycle
      S_HALT_REQ:
        if (debug_halted_i || expired) begin
          state_d = debug_halted_i ? S_HALTED : S_IDLE;
          rsp_v_d = 1'b1;
          rsp_d = debug_halted_i ? RSP_OK : RSP_TIMEOUT;
        end
      default:
        if (debug_running_i || expired) begin
          state_d = debug_running_i ? S_IDLE : S_HALTED;
          rsp_v_d = 1'b1;
          rsp_d = debug_running_i ? RSP_OK : RSP_TIMEOUT;
        end
    endcase
  end
  assign halt_entry = state_d == S_HALTED && (state_q == S_IDLE || state_q == S_HALT_REQ);
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IDLE;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_status_o <= '0;
      debug_req_o <= 1'b0;
      halted_o <= 1'b0;
      have_reset_o <= 1'b0;
      halt_event_o <= 1'b0;
      halt_count_o <= '0;
    end else begin
      state_q <= state_d;
      cmd_ready_o <= state_d == S_IDLE || state_d == S_HALTED;
      rsp_valid_o <= rsp_v_d;
      rsp_status_o <= rsp_d;
      debug_req_o <= state_d == S_HALT_REQ;
      halted_o <= state_d == S_HALTED;
      have_reset_o <= debug_havereset_i || (have_reset_o && !(hs && op == CMD_CLR_RST));
      halt_event_o <= evt_d;
      if (halt_entry && halt_count_o != '1) halt_count_o <= halt_count_o + 1'b1;
    end
endmodule
